// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
//   CLK_HZ   : system clock frequency in Hz
//   BAUD     : line bit rate (also used by the transmitter)
//   BIT_CYC  : clocks per bit, truncated
//   HALF_CYC : clocks per half bit
//   rx_state_e : receiver FSM states
package uart_pkg;

   localparam int unsigned CLK_HZ   = 50_000_000;
   localparam int unsigned BAUD     = 115_200;
   localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
   localparam int unsigned HALF_CYC = BIT_CYC / 2;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Resets to 1 so an idle-high serial line reads as idle.
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
module uart_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_read.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
//   clock_50mhz : system clock, rising edge
//   reset       : synchronous active-high reset
//   rx_pin      : asynchronous serial input, idle high
//   data        : last correctly framed byte, held until the next good frame
//   done        : one-cycle pulse, data updated this cycle
//   frame_err   : one-cycle pulse, stop bit sampled low
//   busy        : high while a frame is being received
module uart_read #(
   parameter int unsigned CLK_HZ = uart_pkg::CLK_HZ,
   parameter int unsigned BAUD   = uart_pkg::BAUD
) (
   input  logic       clock_50mhz,
   input  logic       reset,
   input  logic       rx_pin,
   output logic [7:0] data,
   output logic       done,
   output logic       frame_err,
   output logic       busy
);

   import uart_pkg::*;

   localparam int unsigned RX_BIT_CYC  = CLK_HZ / BAUD;
   localparam int unsigned RX_HALF_CYC = RX_BIT_CYC / 2;
   localparam int unsigned CNT_W       = $clog2(RX_BIT_CYC);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(RX_BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(RX_HALF_CYC - 1);

   logic rx_s;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       idx_q,   idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q,  data_d;
   logic             done_q,  done_d;
   logic             ferr_q,  ferr_d;
   logic             busy_q,  busy_d;

   uart_sync2 u_sync (
      .clk_i (clock_50mhz),
      .rst_i (reset),
      .d_i   (rx_pin),
      .q_o   (rx_s)
   );

   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               // Line back high at mid start bit: treat as a glitch.
               state_d = rx_s ? RX_IDLE : RX_DATA;
               idx_d   = '0;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               shift_d[idx_q] = rx_s;
               // Restart the bit timer for the next data bit within DATA.
               cnt_d          = '0;
               if (idx_q == 3'd7) state_d = RX_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               if (rx_s) begin
                  data_d  = shift_q;
                  done_d  = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // busy drops together with the done/frame_err pulse or on glitch rejection.
      busy_d = (state_d == RX_START) || (state_d == RX_DATA) || (state_d == RX_STOP);
   end

   assign data      = data_q;
   assign done      = done_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_read.sv
// Self-checking bench for uart_read: scoreboard of expected done/frame_err
// events, popped and compared when the receiver pulses.
module tb_uart_read;

   localparam int unsigned BIT = 434;

   logic       clk;
   logic       reset;
   logic       rx_pin;
   logic [7:0] data;
   logic       done;
   logic       frame_err;
   logic       busy;

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned n_done;
   int unsigned n_ferr;

   typedef struct {
      logic [1:0] kind;   // 2'b10 = done, 2'b01 = frame_err
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] last_good;

   uart_read #(
      .CLK_HZ (50_000_000),
      .BAUD   (115_200)
   ) dut (
      .clock_50mhz (clk),
      .reset       (reset),
      .rx_pin      (rx_pin),
      .data        (data),
      .done        (done),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_level(input logic v, input int unsigned cyc);
      rx_pin = v;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned cyc, input logic stop_v);
      drive_level(1'b0, cyc);
      for (int i = 0; i < 8; i++) drive_level(b[i], cyc);
      drive_level(stop_v, cyc);
   endtask

   task automatic expect_done(input logic [7:0] b);
      exp_t e;
      e.kind    = 2'b10;
      e.data    = b;
      last_good = b;
      sb.push_back(e);
   endtask

   task automatic expect_ferr();
      exp_t e;
      e.kind = 2'b01;
      e.data = last_good;
      sb.push_back(e);
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_eq("sb_drain", sb.size(), 0);
   endtask

   // Output monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && (done || frame_err)) begin
         if (done)      n_done++;
         if (frame_err) n_ferr++;
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_pulse", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("pulse_kind", {done, frame_err}, e.kind);
            check_eq("pulse_data", data, e.data);
            check_eq("busy_at_pulse", busy, 0);
         end
      end
   end

   initial begin
      int unsigned fall_t;
      logic        seen_busy;

      n_tests   = 0;
      n_fail    = 0;
      n_done    = 0;
      n_ferr    = 0;
      last_good = 8'h00;
      reset     = 1'b1;
      rx_pin    = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rst_data", data, 8'h00);
      check_eq("rst_done", done, 0);
      check_eq("rst_ferr", frame_err, 0);
      check_eq("rst_busy", busy, 0);
      reset = 1'b0;
      drive_level(1'b1, 20);

      // Nominal frame
      expect_done(8'hA5);
      send_byte(8'hA5, BIT, 1'b1);
      drive_level(1'b1, BIT);
      drain(1000);
      check_eq("a5_busy_after", busy, 0);
      check_eq("a5_data_held", data, 8'hA5);

      // Back-to-back frames, single stop bit
      expect_done(8'h00);
      expect_done(8'hFF);
      send_byte(8'h00, BIT, 1'b1);
      send_byte(8'hFF, BIT, 1'b1);
      drive_level(1'b1, BIT);
      drain(1000);

      // Start glitch: line low for 100 clocks
      rx_pin    = 1'b0;
      fall_t    = 0;
      seen_busy = 1'b0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (n == 100) rx_pin = 1'b1;
         if (busy) seen_busy = 1'b1;
         if (seen_busy && !busy && fall_t == 0) fall_t = n;
      end
      check_eq("glitch_busy_seen", seen_busy, 1);
      check_eq("glitch_busy_fall", fall_t, 220);
      check_eq("glitch_data_held", data, 8'hFF);

      // Framing error, line held low, then recovery
      expect_ferr();
      send_byte(8'h3C, BIT, 1'b0);
      drive_level(1'b0, 1000);
      drive_level(1'b1, BIT);
      drain(100);
      check_eq("ferr_data_held", data, 8'hFF);
      expect_done(8'h55);
      send_byte(8'h55, BIT, 1'b1);
      drive_level(1'b1, BIT);
      drain(1000);

      // Reset in the middle of bit 4 of 0x96 (bit 4 is a 1)
      drive_level(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive_level(logic'((8'h96 >> i) & 8'h01), BIT);
      drive_level(1'b1, BIT / 2);
      check_eq("mid_busy_before_rst", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_data", data, 8'h00);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_ferr", frame_err, 0);
      check_eq("mid_rst_busy", busy, 0);
      last_good = 8'h00;
      drive_level(1'b1, 3);
      reset = 1'b0;
      drive_level(1'b1, 6 * BIT);
      check_eq("post_rst_busy", busy, 0);
      expect_done(8'h81);
      send_byte(8'h81, BIT, 1'b1);
      drive_level(1'b1, BIT);
      drain(1000);

      // +/-2% baud error
      expect_done(8'h5A);
      send_byte(8'h5A, 443, 1'b1);
      drive_level(1'b1, BIT);
      drain(1000);
      expect_done(8'h5A);
      send_byte(8'h5A, 425, 1'b1);
      drive_level(1'b1, BIT);
      drain(1000);

      check_eq("total_done", n_done, 7);
      check_eq("total_ferr", n_ferr, 1);
      check_eq("final_data", data, 8'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_read.md
UART_READ -- requirements
Module: uart_read

Interface
REQ-001 Parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, meaning line bit rate.
REQ-003 Port clock_50mhz  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on clock_50mhz rising edge.
REQ-005 Port rx_pin  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 Port data  output  8  last correctly framed byte; held until the next good frame.
REQ-007 Port done  output  1  one-cycle pulse; data updated this cycle.
REQ-008 Port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 Port busy  output  1  high from start-edge detection until return to IDLE.

Function
REQ-010 rx_pin SHALL pass through a 2-flop synchronizer before any use; all timing references the synchronized signal rx_s.
REQ-011 BIT_CYC SHALL equal CLK_HZ/BAUD, truncated (434 at defaults); HALF_CYC SHALL equal BIT_CYC/2 (217).
REQ-012 The bit counter SHALL be sized as clog2(BIT_CYC) bits and reloaded to 0 on every state change.
REQ-013 States SHALL be: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: rx_s=0 -> START with counter 0 and busy=1; otherwise stay in IDLE with busy=0.
REQ-015 START: at counter=HALF_CYC-1, rx_s=0 -> DATA (bit index 0); rx_s=1 -> IDLE as a glitch, with no pulse output.
REQ-016 DATA: at each counter=BIT_CYC-1, shift rx_s into shift register bit [index] (LSB first); after index 7 -> STOP.
REQ-017 STOP: at counter=BIT_CYC-1, rx_s=1 -> data<=shift register, done=1 on the next cycle, -> IDLE.
REQ-018 STOP sample rx_s=0 -> frame_err=1 on the next cycle; data unchanged; -> WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until rx_s=1, then -> IDLE; no start detection while in WAIT_IDLE.
REQ-020 done and frame_err SHALL be mutually exclusive; each SHALL be high for exactly one clock per frame.
REQ-021 Sample points SHALL lie at mid-bit: HALF_CYC + k*BIT_CYC clocks after start detection, k=1..9.
REQ-022 A start edge arriving in the cycle IDLE is re-entered SHALL be accepted, so back-to-back frames with one stop bit are received.
REQ-023 busy SHALL fall in the same cycle done or frame_err rises (IDLE entry), or on glitch rejection.
REQ-024 No flow control: a new done SHALL overwrite data whether or not the consumer has read the previous byte.

Reset
REQ-025 On reset=1: state=IDLE, counter=0, bit index=0, shift register=0, data=8'h00, done=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done or frame_err pulse; reception resumes on the first start edge after reset release.

Structure
REQ-027 Shared package uart_pkg SHALL hold CLK_HZ, BAUD, the derived BIT_CYC and HALF_CYC, and the rx state enumeration; the transmitter shares the same baud constants.
REQ-028 One sub-module, uart_sync2 (2-flop synchronizer, reset value 1), SHALL be instantiated; the FSM, counter and datapath SHALL be local to uart_read.

Verification
REQ-029 Drive 0xA5 at 434 clocks/bit -> one done pulse, data=8'hA5, frame_err never high, busy low after done.
REQ-030 Drive 0x00, then 0xFF, back-to-back with a single stop bit -> two done pulses, data 8'h00 then 8'hFF.
REQ-031 Drive rx_pin low for 100 clocks, then high -> no done, no frame_err, busy returns to 0 at about clock 220.
REQ-032 Drive 0x3C with the stop bit low, hold the line low 1000 clocks, then high -> one frame_err pulse, data keeps its prior value, and the next frame 0x55 is received with data=8'h55.
REQ-033 Assert reset during bit 4 of 0x96 -> all outputs 0 next cycle, no pulse, and the following 0x81 frame is received correctly.
REQ-034 Drive 0x5A with ±2% baud error -> done pulse, data=8'h5A.
